mul_disp_ctrl: RTL and testbench
================================

MUL_DISP_CTRL -- requirements
Module: mul_disp_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, clk cycles per scan_en pulse (legal range >= 2).
REQ-002 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to capture and convert a new result.
REQ-005 SHALL have port a, input, 4, multiplicand.
REQ-006 SHALL have port b, input, 4, multiplier.
REQ-007 SHALL have port p, input, 8, product from the multiplier datapath.
REQ-008 SHALL have port busy, output, 1, conversion in progress.
REQ-009 SHALL have port done, output, 1, one-cycle pulse when new digits are committed.
REQ-010 SHALL have ports D0..D7, output, 4 each, BCD digits for the 8-digit display mux.
REQ-011 SHALL have port blank, output, 8, per-digit blank mask; bit n covers Dn.
REQ-012 SHALL have port scan_en, output, 1, digit-scan advance pulse for the display counter.

Function
REQ-013 SHALL implement FSM states IDLE, CONV, COMMIT.
REQ-014 In IDLE, start=1 at an edge SHALL latch a, b, p into shadow registers and enter CONV; busy=1 from that edge.
REQ-015 start SHALL be ignored outside IDLE; there is no queuing.
REQ-016 CONV SHALL time-share one converter across three jobs in fixed order: p, then {4'b0,a}, then {4'b0,b}.
REQ-017 Each job SHALL take 9 cycles: 1 load cycle and 8 shift-add-3 cycles.
REQ-018 After the third job the FSM SHALL enter COMMIT.
REQ-019 COMMIT SHALL update D0..D7 and blank in one edge and assert done for exactly one cycle.
REQ-020 The same COMMIT edge SHALL drop busy and return to IDLE.
REQ-021 Latency: with start sampled at edge 0, done and the new digits SHALL be visible after edge 28.
REQ-022 D0..D7 SHALL change only at COMMIT, so the display never shows partial results.
REQ-023 Digit map: D0/D1/D2 = p ones/tens/hundreds; D3 = 0; D4/D5 = b ones/tens; D6/D7 = a ones/tens.
REQ-024 Conversion SHALL be exact for p in 0..255 (no saturation); p is not checked against a*b.
REQ-025 start=1 in the cycle done=1 SHALL be accepted, since the FSM is already in IDLE.
REQ-026 scan_en SHALL be driven by a free-running counter 0..SCAN_DIV-1.
REQ-027 scan_en SHALL be 1 for one cycle when the counter equals SCAN_DIV-1, then wrap to 0.
REQ-028 The scan counter SHALL be independent of start, busy and the FSM.

Reset
REQ-029 reset=1 at an edge SHALL force IDLE, busy=0, done=0, D0..D7=0, blank=8'h00, scan counter=0, scan_en=0.
REQ-030 reset SHALL take priority over start.
REQ-031 reset mid-CONV SHALL abort the conversion with no done pulse and leave digits at 0.

Configuration
REQ-032 Macro SEG_LZB_EN, when defined, SHALL enable leading-zero blanking at COMMIT with these rules:
- D3 always blanked.
- D2 blanked if hundreds=0; D1 blanked if hundreds=0 and tens=0; D0 never blanked.
- D5 blanked if b tens=0; D7 blanked if a tens=0; D4 and D6 never blanked.
REQ-033 Without SEG_LZB_EN, blank SHALL be constant 8'h00 and no blanking logic is synthesised.

Structure
REQ-034 Package seg_ctrl_pkg SHALL hold the FSM state enum, the job index constants (JOB_P=0, JOB_A=1, JOB_B=2), the shift count (8) and the SCAN_DIV default.
REQ-035 Sub-module bin2bcd_seq SHALL implement the shared 8-bit sequential double-dabble converter, with ports load, bin[7:0], bcd[11:0] and valid.

Verification
REQ-036 Reset: hold reset 3 cycles -> D0..D7=0, busy=0, done=0, blank=0, scan_en=0.
REQ-037 a=15, b=15, p=225, start pulse at edge 0 -> done only after edge 28; D7..D0 = 1,5,1,5,0,2,2,5.
REQ-038 SEG_LZB_EN defined; a=3, b=0, p=0 -> D7..D0 = 0,3,0,0,0,0,0,0; blank=8'b1010_1110.
REQ-039 Second start at edge 10 with changed inputs -> ignored; exactly one done at edge 28 carrying the first operands.
REQ-040 reset at edge 15 mid-CONV -> no done, digits 0; a new start at edge 20 completes after edge 48.
REQ-041 SCAN_DIV=4 -> scan_en high for one cycle after edges 4, 8, 12, ... regardless of start or busy activity.

Source files
------------

// File: rtl/seg_ctrl_pkg.sv
// Shared types and constants for the multiplier display controller.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package seg_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_e;

    // Converter job order inside CONV.
    localparam logic [1:0] JOB_P = 2'd0;
    localparam logic [1:0] JOB_A = 2'd1;
    localparam logic [1:0] JOB_B = 2'd2;

    // One shift per binary input bit.
    localparam int SHIFT_CNT    = 8;
    localparam int SCAN_DIV_DEF = 100000;

    // Double-dabble digit correction: add 3 to any BCD digit >= 5 before the shift.
    function automatic logic [3:0] dd_adj(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (double dabble).
// Latency: load edge + 8 shift edges; valid is high the cycle after the 8th shift.
// Backpressure: none; a new load restarts the conversion immediately.
// Ports: clk, reset (sync, active high), load, bin[7:0] in; bcd[11:0], valid out.
module bin2bcd_seq
    import seg_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [7:0]  bin,
    output logic [11:0] bcd,
    output logic        valid
);

    logic [7:0]  sh_q;
    logic [11:0] bcd_q;
    logic [3:0]  cnt_q;
    logic        valid_q;
    logic [3:0]  adj_t;
    logic [3:0]  adj_o;

    // The hundreds digit never exceeds 2 for an 8-bit input, so it needs no correction.
    assign adj_t = dd_adj(bcd_q[7:4]);
    assign adj_o = dd_adj(bcd_q[3:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q    <= 8'd0;
            bcd_q   <= 12'd0;
            cnt_q   <= 4'd0;
            valid_q <= 1'b0;
        end else if (load) begin
            sh_q    <= bin;
            bcd_q   <= 12'd0;
            cnt_q   <= 4'(SHIFT_CNT);
            valid_q <= 1'b0;
        end else if (cnt_q != 4'd0) begin
            sh_q    <= {sh_q[6:0], 1'b0};
            bcd_q   <= {bcd_q[10:8], adj_t, adj_o, sh_q[7]};
            cnt_q   <= cnt_q - 4'd1;
            valid_q <= (cnt_q == 4'd1);
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign bcd   = bcd_q;
    assign valid = valid_q;

endmodule

// File: rtl/mul_disp_ctrl.sv
// Captures a, b, p on start, converts all three to BCD with one shared converter and
// commits them to an 8-digit display in a single edge; also generates the scan pulse.
// Latency: start at edge 0 -> done and new digits after edge 28; start ignored while busy.
// Ports: clk, reset, start, a[3:0], b[3:0], p[7:0] in; busy, done, D0..D7[3:0], blank[7:0],
//        scan_en out. Optional leading-zero blanking: define SEG_LZB_EN.
module mul_disp_ctrl
    import seg_ctrl_pkg::*;
#(
    parameter int SCAN_DIV = SCAN_DIV_DEF
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [7:0] p,
    output logic       busy,
    output logic       done,
    output logic [3:0] D0,
    output logic [3:0] D1,
    output logic [3:0] D2,
    output logic [3:0] D3,
    output logic [3:0] D4,
    output logic [3:0] D5,
    output logic [3:0] D6,
    output logic [3:0] D7,
    output logic [7:0] blank,
    output logic       scan_en
);

    localparam int CW = $clog2(SCAN_DIV);

    state_e          state_q;
    logic [1:0]      job_q;
    logic [3:0]      cyc_q;
    logic [3:0]      a_q;
    logic [3:0]      b_q;
    logic [7:0]      p_q;
    logic [11:0]     res_p_q;
    logic [7:0]      res_a_q;
    logic            busy_q;
    logic            done_q;
    logic [7:0][3:0] disp_q;

    logic            conv_load;
    logic [7:0]      conv_bin;
    logic [11:0]     conv_bcd;
    logic            conv_vld;

    // Cycle 0 of every job loads the converter; cycles 1..8 are its shifts.
    assign conv_load = (state_q == CONV) && (cyc_q == 4'd0);

    always_comb begin
        conv_bin = p_q;
        case (job_q)
            JOB_A:   conv_bin = {4'b0, a_q};
            JOB_B:   conv_bin = {4'b0, b_q};
            default: conv_bin = p_q;
        endcase
    end

    bin2bcd_seq u_conv (
        .clk   (clk),
        .reset (reset),
        .load  (conv_load),
        .bin   (conv_bin),
        .bcd   (conv_bcd),
        .valid (conv_vld)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            job_q   <= JOB_P;
            cyc_q   <= 4'd0;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            p_q     <= 8'd0;
            res_p_q <= 12'd0;
            res_a_q <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            disp_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        p_q     <= p;
                        job_q   <= JOB_P;
                        cyc_q   <= 4'd0;
                        busy_q  <= 1'b1;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    // The previous job's result is valid during the next job's load cycle.
                    if (conv_vld && job_q == JOB_A) begin
                        res_p_q <= conv_bcd;
                    end
                    if (conv_vld && job_q == JOB_B) begin
                        res_a_q <= conv_bcd[7:0];
                    end
                    if (cyc_q == 4'(SHIFT_CNT)) begin
                        cyc_q <= 4'd0;
                        if (job_q == JOB_B) begin
                            state_q <= COMMIT;
                        end else begin
                            job_q <= job_q + 2'd1;
                        end
                    end else begin
                        cyc_q <= cyc_q + 4'd1;
                    end
                end
                COMMIT: begin
                    // conv_bcd still holds the b result here (valid is high this cycle).
                    disp_q[0] <= res_p_q[3:0];
                    disp_q[1] <= res_p_q[7:4];
                    disp_q[2] <= res_p_q[11:8];
                    disp_q[3] <= 4'd0;
                    disp_q[4] <= conv_bcd[3:0];
                    disp_q[5] <= conv_bcd[7:4];
                    disp_q[6] <= res_a_q[3:0];
                    disp_q[7] <= res_a_q[7:4];
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SEG_LZB_EN
    logic [7:0] blank_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            blank_q <= 8'h00;
        end else if (state_q == COMMIT) begin
            blank_q[0] <= 1'b0;
            blank_q[1] <= (res_p_q[11:8] == 4'd0) && (res_p_q[7:4] == 4'd0);
            blank_q[2] <= (res_p_q[11:8] == 4'd0);
            blank_q[3] <= 1'b1;
            blank_q[4] <= 1'b0;
            blank_q[5] <= (conv_bcd[7:4] == 4'd0);
            blank_q[6] <= 1'b0;
            blank_q[7] <= (res_a_q[7:4] == 4'd0);
        end
    end

    assign blank = blank_q;
`else
    assign blank = 8'h00;
`endif

    // Free-running scan divider, independent of the conversion FSM.
    logic [CW-1:0] scan_cnt_q;
    logic          scan_en_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt_q <= '0;
            scan_en_q  <= 1'b0;
        end else begin
            scan_en_q <= (scan_cnt_q == CW'(SCAN_DIV - 1));
            if (scan_cnt_q == CW'(SCAN_DIV - 1)) begin
                scan_cnt_q <= '0;
            end else begin
                scan_cnt_q <= scan_cnt_q + 1'b1;
            end
        end
    end

    assign scan_en = scan_en_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign D0      = disp_q[0];
    assign D1      = disp_q[1];
    assign D2      = disp_q[2];
    assign D3      = disp_q[3];
    assign D4      = disp_q[4];
    assign D5      = disp_q[5];
    assign D6      = disp_q[6];
    assign D7      = disp_q[7];

endmodule

// File: tb/tb_mul_disp_ctrl.sv
// Self-checking bench for mul_disp_ctrl: directed corner cases plus randomized transactions
// against a decimal-arithmetic display model; scan pulse checked every cycle.
// Latency/backpressure: expects done 28 edges after the start edge; start ignored while busy.
module tb_mul_disp_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
    logic       busy;
    logic       done;
    logic [3:0] D0, D1, D2, D3, D4, D5, D6, D7;
    logic [7:0] blank;
    logic       scan_en;
    logic [3:0] dout [8];

    int n_chk  = 0;
    int n_pass = 0;
    int exp_d [8];
    int exp_blank;
    int ecnt = -1;

    always #5 clk = ~clk;

    mul_disp_ctrl #(.SCAN_DIV(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .p       (p),
        .busy    (busy),
        .done    (done),
        .D0      (D0),
        .D1      (D1),
        .D2      (D2),
        .D3      (D3),
        .D4      (D4),
        .D5      (D5),
        .D6      (D6),
        .D7      (D7),
        .blank   (blank),
        .scan_en (scan_en)
    );

    assign dout[0] = D0;
    assign dout[1] = D1;
    assign dout[2] = D2;
    assign dout[3] = D3;
    assign dout[4] = D4;
    assign dout[5] = D5;
    assign dout[6] = D6;
    assign dout[7] = D7;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Display model: decimal digits of the operands, computed arithmetically.
    function automatic void model_commit(input int ma, input int mb, input int mp);
        exp_d[0] = mp % 10;
        exp_d[1] = (mp / 10) % 10;
        exp_d[2] = mp / 100;
        exp_d[3] = 0;
        exp_d[4] = mb % 10;
        exp_d[5] = mb / 10;
        exp_d[6] = ma % 10;
        exp_d[7] = ma / 10;
`ifdef SEG_LZB_EN
        exp_blank = 8;
        if (mp < 100) exp_blank += 4;
        if (mp < 10)  exp_blank += 2;
        if (mb < 10)  exp_blank += 32;
        if (ma < 10)  exp_blank += 128;
`else
        exp_blank = 0;
`endif
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) exp_d[i] = 0;
        exp_blank = 0;
    endfunction

    task automatic check_disp(input string tag);
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s D%0d", tag, i), int'(dout[i]), exp_d[i]);
        chk({tag, " blank"}, int'(blank), exp_blank);
    endtask

    // Scan pulse: high after every 4th edge following the last reset edge.
    always @(posedge clk) begin
        if (reset) ecnt = 0;
        else if (ecnt >= 0) ecnt = ecnt + 1;
    end

    always @(negedge clk) begin
        if (ecnt >= 0)
            chk("scan_en", int'(scan_en), (ecnt > 0 && ecnt % 4 == 0) ? 1 : 0);
    end

    // One transaction. Returns #1 after the edge where done is observed.
    // now=1: issue start in the current cycle (used right after a done, back to back).
    task automatic txn(input int ta, input int tbv, input int tp, input bit now, input bit inject);
        int lat;
        lat = 0;
        if (!now) begin
            @(posedge clk); #1;
        end
        a = 4'(ta); b = 4'(tbv); p = 8'(tp); start = 1'b1;
        @(posedge clk); #1;                      // edge 0
        start = 1'b0;
        a = 4'($urandom); b = 4'($urandom); p = 8'($urandom);
        chk("busy after start", int'(busy), 1);
        for (int k = 1; k <= 40; k++) begin
            if (inject && k == 10) begin
                start = 1'b1;
                a = 4'(ta + 1); b = 4'(tbv + 3); p = 8'(tp + 7);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;                  // edge k
            if (k == 1) begin
                chk("done low early", int'(done), 0);
                chk("busy mid", int'(busy), 1);
            end
            if (k == 14) check_disp("held");
            if (done) begin
                lat = k;
                break;
            end
        end
        chk("latency", lat, 28);
        model_commit(ta, tbv, tp);
        check_disp("commit");
        chk("busy at commit", int'(busy), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        int pv [6];
        pv = '{0, 9, 10, 99, 100, 255};
        reset = 1'b1; start = 1'b0; a = 4'd0; b = 4'd0; p = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        check_disp("reset");
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset scan_en", int'(scan_en), 0);
        reset = 1'b0;

        txn(15, 15, 225, 1'b0, 1'b0);
        txn(3, 0, 0, 1'b0, 1'b0);

        // Second start during CONV must be ignored.
        txn(9, 12, 108, 1'b0, 1'b1);
        ndone = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("extra done after ignored start", ndone, 0);
        check_disp("ignored start");

        // Reset mid-CONV at edge 15, then a new start at edge 20.
        @(posedge clk); #1;
        a = 4'd7; b = 4'd8; p = 8'd56; start = 1'b1;
        @(posedge clk); #1;                      // edge 0
        start = 1'b0;
        ndone = 0;
        for (int k = 1; k <= 48; k++) begin
            reset = (k == 15);
            start = (k == 20);
            if (k == 20) begin
                a = 4'd4; b = 4'd11; p = 8'd44;
            end
            @(posedge clk); #1;
            if (k == 15) begin
                model_reset();
                check_disp("mid reset");
                chk("mid reset busy", int'(busy), 0);
            end
            if (k < 48 && done) ndone++;
            if (k == 48) begin
                chk("done after restart", int'(done), 1);
                model_commit(4, 11, 44);
                check_disp("restart");
            end
        end
        reset = 1'b0; start = 1'b0;
        chk("done count around reset", ndone, 0);

        // Randomized transactions, some back to back with done.
        for (int i = 0; i < 25; i++) begin
            int ta, tbv, tp;
            bit now;
            ta  = $urandom_range(0, 15);
            tbv = $urandom_range(0, 15);
            if (i < 6) tp = pv[i];
            else if ($urandom_range(0, 1) == 1) tp = ta * tbv;
            else tp = $urandom_range(0, 255);
            now = (i > 0) && ($urandom_range(0, 2) == 0);
            if (!now) repeat ($urandom_range(0, 5)) @(posedge clk);
            txn(ta, tbv, tp, now, 1'b0);
        end

        @(posedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
